// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths, register address type and ALU op encoding
package operand_fetch_pkg;
   localparam int kDATA_W   = 8;
   localparam int kNUM_REGS = 16;
   localparam int kOP_W     = 4;
   typedef logic [$clog2(kNUM_REGS)-1:0] reg_addr_t;
   typedef enum logic [kOP_W-1:0] {
      kPASS_INPUTA = 4'h0,
      kPASS_INPUTB = 4'h1,
      kADD         = 4'h2,
      kSUB         = 4'h3,
      kAND         = 4'h4,
      kOR          = 4'h5,
      kXOR         = 4'h6,
      kNOT         = 4'h7,
      kSHL         = 4'h8,
      kSHR         = 4'h9
   } op_t;
endpackage

// File: rtl/operand_fetch_reg_file_core.sv
// reg_file_core: register storage, one write port, two combinational read ports
// Ports: clk, rst_n (async, active low); we/waddr/wdata write port;
//        raddr_a/raddr_b -> rdata_a/rdata_b read ports.
// R0 and addresses at or beyond NUM_REGS read as zero and ignore writes.
module reg_file_core
   import operand_fetch_pkg::*;
#(
   parameter int DATA_W   = kDATA_W,
   parameter int NUM_REGS = kNUM_REGS,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);
   localparam int DEPTH = 1 << AW;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              waddr_ok;
   assign waddr_ok = waddr != '0 && int'(waddr) < NUM_REGS;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we && waddr_ok) begin
         mem[waddr] <= wdata;
      end
   end
   assign rdata_a = (raddr_a == '0 || int'(raddr_a) >= NUM_REGS) ? '0 : mem[raddr_a];
   assign rdata_b = (raddr_b == '0 || int'(raddr_b) >= NUM_REGS) ? '0 : mem[raddr_b];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register file read with writeback bypass, registered ALU operands, carry flag
// Ports: clk, rst_n (async, active low);
//        issue_valid/alu_op_in/rd_addr_a/rd_addr_b from decode; stall from downstream;
//        wr_en/wr_addr/wr_data writeback (ALU Out); carry_wr_en/carry_in (ALU CarryOut);
//        alu_op/input_a/input_b/op_valid to the ALU; carry_flag architectural carry.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int DATA_W   = kDATA_W,
   parameter int NUM_REGS = kNUM_REGS,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  op_t               alu_op_in,
   input  logic [AW-1:0]     rd_addr_a,
   input  logic [AW-1:0]     rd_addr_b,
   input  logic              stall,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              carry_wr_en,
   input  logic              carry_in,
   output op_t               alu_op,
   output logic [DATA_W-1:0] input_a,
   output logic [DATA_W-1:0] input_b,
   output logic              op_valid,
   output logic              carry_flag
);
   logic [DATA_W-1:0] rf_a, rf_b, rd_a, rd_b;
   logic [AW-1:0]     cap_a, cap_b;
   logic              wr_ok;
   // A write that will actually land; only such writes may bypass or refresh,
   // so R0 and out-of-range addresses keep reading zero.
   assign wr_ok = wr_en && wr_addr != '0 && int'(wr_addr) < NUM_REGS;
   reg_file_core #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_en),
      .waddr   (wr_addr),
      .wdata   (wr_data),
      .raddr_a (rd_addr_a),
      .raddr_b (rd_addr_b),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );
   assign rd_a = (wr_ok && wr_addr == rd_addr_a) ? wr_data : rf_a;
   assign rd_b = (wr_ok && wr_addr == rd_addr_b) ? wr_data : rf_b;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op   <= kPASS_INPUTA;
         input_a  <= '0;
         input_b  <= '0;
         op_valid <= 1'b0;
         cap_a    <= '0;
         cap_b    <= '0;
      end else if (stall) begin
         // Held operands track writebacks to their source so they never go stale.
         if (wr_ok && wr_addr == cap_a) input_a <= wr_data;
         if (wr_ok && wr_addr == cap_b) input_b <= wr_data;
      end else begin
         alu_op   <= alu_op_in;
         op_valid <= issue_valid;
         input_a  <= rd_a;
         input_b  <= rd_b;
         cap_a    <= rd_addr_a;
         cap_b    <= rd_addr_b;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) carry_flag <= 1'b0;
      else if (carry_wr_en) carry_flag <= carry_in;
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector table plus randomized run against a reference model
module tb_operand_fetch;
   import operand_fetch_pkg::*;
   localparam int AW = $clog2(kNUM_REGS);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          issue_valid = 1'b0;
   op_t           alu_op_in = kPASS_INPUTA;
   logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
   logic          stall = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          carry_wr_en = 1'b0, carry_in = 1'b0;
   op_t           alu_op;
   logic [7:0]    input_a, input_b;
   logic          op_valid, carry_flag;

   int n_vec = 0;
   int n_err = 0;

   operand_fetch dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .alu_op_in(alu_op_in),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .stall(stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .carry_wr_en(carry_wr_en), .carry_in(carry_in),
      .alu_op(alu_op), .input_a(input_a), .input_b(input_b),
      .op_valid(op_valid), .carry_flag(carry_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st, iv; op_t op; int ra, rb, we, wa, wd, cwe, ci;
      int ev; op_t eop; int ea, eb, ec;
   } vec_t;
   vec_t tbl[13];

   // Reference model: architectural register contents and what the ALU should see.
   logic [7:0] m_regs [kNUM_REGS];
   logic [7:0] m_a, m_b;
   op_t        m_op;
   logic       m_v, m_c;
   int         src_a, src_b;

   task automatic model_reset();
      for (int i = 0; i < kNUM_REGS; i++) m_regs[i] = 8'h00;
      m_a = 8'h00; m_b = 8'h00; m_op = kPASS_INPUTA; m_v = 1'b0; m_c = 1'b0;
      src_a = 0; src_b = 0;
   endtask

   function automatic logic [7:0] ref_read(input int a);
      if (a == 0) return 8'h00;
      if (wr_en && int'(wr_addr) == a) return wr_data;
      return m_regs[a];
   endfunction

   // Apply the rules of one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      if (!stall) begin
         m_v = issue_valid; m_op = alu_op_in;
         m_a = ref_read(int'(rd_addr_a)); m_b = ref_read(int'(rd_addr_b));
         src_a = int'(rd_addr_a); src_b = int'(rd_addr_b);
      end else begin
         if (wr_en && src_a != 0 && int'(wr_addr) == src_a) m_a = wr_data;
         if (wr_en && src_b != 0 && int'(wr_addr) == src_b) m_b = wr_data;
      end
      if (wr_en && wr_addr != '0) m_regs[int'(wr_addr)] = wr_data;
      if (carry_wr_en) m_c = carry_in;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input op_t eop,
                          input logic [7:0] ea, input logic [7:0] eb, input logic ec);
      chk({tag, ".op_valid"}, {7'b0, op_valid}, {7'b0, ev});
      chk({tag, ".alu_op"}, {4'b0, alu_op}, {4'b0, eop});
      chk({tag, ".input_a"}, input_a, ea);
      chk({tag, ".input_b"}, input_b, eb);
      chk({tag, ".carry_flag"}, {7'b0, carry_flag}, {7'b0, ec});
   endtask

   task automatic apply(input vec_t v);
      stall = v.st[0]; issue_valid = v.iv[0]; alu_op_in = v.op;
      rd_addr_a = v.ra[AW-1:0]; rd_addr_b = v.rb[AW-1:0];
      wr_en = v.we[0]; wr_addr = v.wa[AW-1:0]; wr_data = v.wd[7:0];
      carry_wr_en = v.cwe[0]; carry_in = v.ci[0];
   endtask

   initial begin
      //           st iv op            ra rb we wa wd     cwe ci  ev eop           ea     eb     ec
      tbl[0]  = '{0, 0, kPASS_INPUTA, 0, 0, 1, 3, 'h22, 0, 0,  0, kPASS_INPUTA, 0,     0,     0};
      tbl[1]  = '{0, 1, kADD,         3, 0, 0, 0, 0,    0, 0,  1, kADD,         'h22,  0,     0};
      tbl[2]  = '{0, 1, kSUB,         5, 5, 1, 5, 'h7F, 0, 0,  1, kSUB,         'h7F,  'h7F,  0};
      tbl[3]  = '{0, 1, kAND,         0, 5, 1, 0, 'hFF, 0, 0,  1, kAND,         0,     'h7F,  0};
      tbl[4]  = '{0, 0, kPASS_INPUTB, 0, 0, 1, 2, 'h01, 0, 0,  0, kPASS_INPUTB, 0,     0,     0};
      tbl[5]  = '{0, 1, kOR,          3, 2, 0, 0, 0,    0, 0,  1, kOR,          'h22,  'h01,  0};
      tbl[6]  = '{1, 1, kXOR,         5, 5, 1, 2, 'h10, 0, 0,  1, kOR,          'h22,  'h10,  0};
      tbl[7]  = '{1, 1, kXOR,         5, 5, 1, 3, 'h33, 0, 0,  1, kOR,          'h33,  'h10,  0};
      tbl[8]  = '{0, 1, kADD,         2, 3, 0, 0, 0,    0, 0,  1, kADD,         'h10,  'h33,  0};
      tbl[9]  = '{0, 0, kPASS_INPUTA, 0, 0, 0, 0, 0,    1, 1,  0, kPASS_INPUTA, 0,     0,     1};
      tbl[10] = '{0, 0, kPASS_INPUTA, 0, 0, 0, 0, 0,    0, 0,  0, kPASS_INPUTA, 0,     0,     1};
      tbl[11] = '{0, 0, kPASS_INPUTA, 0, 0, 0, 0, 0,    1, 0,  0, kPASS_INPUTA, 0,     0,     0};
      tbl[12] = '{1, 1, kADD,         4, 4, 1, 0, 'hAA, 0, 0,  0, kPASS_INPUTA, 0,     0,     0};

      model_reset();
      #3;
      chk_all("reset0", 1'b0, kPASS_INPUTA, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         model_edge();
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].ev[0], tbl[i].eop,
                 tbl[i].ea[7:0], tbl[i].eb[7:0], tbl[i].ec[0]);
      end

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         stall       = $urandom_range(0, 9) < 3;
         issue_valid = $urandom_range(0, 1) == 1;
         alu_op_in   = op_t'($urandom_range(0, 9));
         rd_addr_a   = AW'($urandom_range(0, kNUM_REGS - 1));
         rd_addr_b   = ($urandom_range(0, 4) == 0) ? rd_addr_a : AW'($urandom_range(0, kNUM_REGS - 1));
         wr_en       = $urandom_range(0, 1) == 1;
         wr_addr     = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, kNUM_REGS - 1));
         wr_data     = 8'($urandom);
         carry_wr_en = $urandom_range(0, 2) == 0;
         carry_in    = $urandom_range(0, 1) == 1;
         model_edge();
         @(posedge clk);
         #1;
         chk_all($sformatf("rnd%0d", i), m_v, m_op, m_a, m_b, m_c);
      end

      // Populate state so the asynchronous reset has something to clear.
      @(negedge clk);
      stall = 1'b0; issue_valid = 1'b1; alu_op_in = kSUB;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
      carry_wr_en = 1'b1; carry_in = 1'b1;
      model_edge();
      @(posedge clk);
      #1;
      chk_all("prerst", 1'b1, kSUB, 8'h5A, 8'h5A, 1'b1);
      @(negedge clk);
      stall = 1'b1; wr_en = 1'b0; carry_wr_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_all("midrst", 1'b0, kPASS_INPUTA, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      stall = 1'b0; issue_valid = 1'b1; alu_op_in = kADD; rd_addr_a = 4'd3; rd_addr_b = 4'd5;
      model_edge();
      @(posedge clk);
      #1;
      chk_all("postrst", 1'b1, kADD, 8'h00, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
